// File: rtl/sumsq_top.sv
// sumsq_top: sequential x^2+y^2+z^2 engine built around one shared shift-add multiplier.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module sumsq_top #(
  parameter int MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        start,
  input  logic [7:0]  x_val,
  input  logic [7:0]  y_val,
  input  logic [7:0]  z_val,
  output logic        done,
  output logic [17:0] result,
  input  logic        rst_n
);

  localparam int         SLICES     = 8 / MUL_BITS;
  localparam logic [2:0] LAST_SLICE = 3'(SLICES - 1);
  localparam logic [7:0] DIGIT_MASK = 8'((1 << MUL_BITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  x_q, y_q, z_q;
  logic [2:0]  slice_q;
  logic [1:0]  opnd_q;
  logic [17:0] acc_q;
  logic [17:0] result_q;
  logic        done_q;

  logic [7:0]  op_cur;
  logic [3:0]  shamt;
  logic [7:0]  digit;
  logic [17:0] term;
  logic [17:0] acc_d;

  always_comb begin
    op_cur = z_q;
    case (opnd_q)
      2'd0:    op_cur = x_q;
      2'd1:    op_cur = y_q;
      default: op_cur = z_q;
    endcase
  end

  // One partial product per cycle: whole operand times its current slice, placed at the slice weight.
  assign shamt = 4'(32'(slice_q) * MUL_BITS);
  assign digit = (op_cur >> shamt) & DIGIT_MASK;
  assign term  = (18'(op_cur) * 18'(digit)) << shamt;
  assign acc_d = acc_q + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      z_q      <= 8'd0;
      slice_q  <= 3'd0;
      opnd_q   <= 2'd0;
      acc_q    <= 18'd0;
      result_q <= 18'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_val;
            y_q     <= y_val;
            z_q     <= z_val;
            acc_q   <= 18'd0;
            slice_q <= 3'd0;
            opnd_q  <= 2'd0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (slice_q == LAST_SLICE) begin
            slice_q <= 3'd0;
            if (opnd_q == 2'd2) begin
              state_q <= S_DONE;
            end else begin
              opnd_q <= opnd_q + 2'd1;
            end
          end else begin
            slice_q <= slice_q + 3'd1;
          end
        end
        S_DONE: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_sumsq_top.sv
// tb_sumsq_top: randomized self-checking bench for sumsq_top at MUL_BITS = 1, 2, 4, 8.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_sumsq_top;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  x_val, y_val, z_val;
  logic [3:0]  done_w;
  logic [17:0] result_w [4];

  int checks = 0;
  int passed = 0;

  // Per-instance observations from the last watch window
  int          pulses    [4];
  int          first_lat [4];
  logic [17:0] res_seen  [4];
  logic [17:0] mid_res   [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      sumsq_top #(.MUL_BITS(1 << g)) u_dut (
        .clk    (clk),
        .start  (start),
        .x_val  (x_val),
        .y_val  (y_val),
        .z_val  (z_val),
        .done   (done_w[g]),
        .result (result_w[g]),
        .rst_n  (rst_n)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_sumsq(input int x, input int y, input int z);
    return x * x + y * y + z * z;
  endfunction

  function automatic int model_latency(input int idx);
    return 3 * (8 / (1 << idx)) + 1;
  endfunction

  // Single-cycle start; returns #1 after the sampling edge.
  task automatic pulse_start(input int x, input int y, input int z);
    @(negedge clk);
    x_val = 8'(x);
    y_val = 8'(y);
    z_val = 8'(z);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Watch ncyc cycles after the start edge; optionally scramble operands each cycle.
  task automatic watch(input int ncyc, input bit scramble);
    for (int i = 0; i < 4; i++) begin
      pulses[i] = 0; first_lat[i] = 0; res_seen[i] = '0; mid_res[i] = '0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      if (scramble) begin
        #1;
        x_val = 8'($urandom_range(0, 255));
        y_val = 8'($urandom_range(0, 255));
        z_val = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (k == 2) mid_res[i] = result_w[i];
        if (done_w[i]) begin
          pulses[i]++;
          if (first_lat[i] == 0) first_lat[i] = k;
          res_seen[i] = result_w[i];
        end
      end
    end
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x_val = 8'd9; y_val = 8'd9; z_val = 8'd9;
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done_w[i] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", i, done_w[i]);
      else passed++;
      checks++;
      if (result_w[i] !== 18'd0) $display("FAIL reset_result[%0d]: got %0d want 0", i, result_w[i]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_w !== 4'b0) $display("FAIL idle_no_done: got %b want 0000", done_w);
    else passed++;
  endtask

  task automatic test_basic();
    int exp;
    exp = model_sumsq(5, 71, 255);
    pulse_start(5, 71, 255);
    watch(30, 1'b0);
    checks++;
    if (first_lat[2] != model_latency(2)) $display("FAIL basic_latency: got %0d want %0d", first_lat[2], model_latency(2));
    else passed++;
    checks++;
    if (pulses[2] != 1) $display("FAIL basic_pulses: got %0d want 1", pulses[2]);
    else passed++;
    checks++;
    if (res_seen[2] !== 18'(exp)) $display("FAIL basic_result: got %0d want %0d", res_seen[2], exp);
    else passed++;
    checks++;
    if (result_w[2] !== 18'(exp)) $display("FAIL basic_result_held: got %0d want %0d", result_w[2], exp);
    else passed++;
  endtask

  task automatic test_corners();
    int vals [2] = '{255, 0};
    for (int v = 0; v < 2; v++) begin
      pulse_start(vals[v], vals[v], vals[v]);
      watch(30, 1'b0);
      checks++;
      if (res_seen[2] !== 18'(model_sumsq(vals[v], vals[v], vals[v])))
        $display("FAIL corner_result(%0d): got %0d want %0d", vals[v], res_seen[2], model_sumsq(vals[v], vals[v], vals[v]));
      else passed++;
      checks++;
      if (pulses[2] != 1) $display("FAIL corner_pulses(%0d): got %0d want 1", vals[v], pulses[2]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int x, y, z, exp;
    for (int n = 0; n < 6; n++) begin
      x = $urandom_range(0, 255); y = $urandom_range(0, 255); z = $urandom_range(0, 255);
      exp = model_sumsq(x, y, z);
      pulse_start(x, y, z);
      watch(30, 1'b0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res_seen[i] !== 18'(exp) || first_lat[i] != model_latency(i))
          $display("FAIL random[%0d] mb=%0d: got result %0d lat %0d want result %0d lat %0d",
                   n, 1 << i, res_seen[i], first_lat[i], exp, model_latency(i));
        else passed++;
      end
    end
  endtask

  task automatic test_operand_hold();
    int x, y, z, exp, prev;
    prev = int'(result_w[2]);
    x = $urandom_range(1, 255); y = $urandom_range(1, 255); z = $urandom_range(1, 255);
    exp = model_sumsq(x, y, z);
    pulse_start(x, y, z);
    watch(30, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_seen[i] !== 18'(exp)) $display("FAIL hold_result[%0d]: got %0d want %0d", i, res_seen[i], exp);
      else passed++;
    end
    checks++;
    if (mid_res[2] !== 18'(prev)) $display("FAIL hold_result_during_calc: got %0d want %0d", mid_res[2], prev);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit exp_done [32];
    int exp, t;
    exp = model_sumsq(17, 200, 3);
    for (int k = 0; k < 32; k++) exp_done[k] = 1'b0;
    // Start is seen on edges 0..19 whenever the engine is idle; each run takes 7 busy cycles + 1 idle.
    t = 0;
    while (t <= 19) begin
      exp_done[t + model_latency(2)] = 1'b1;
      t += model_latency(2) + 1;
    end
    @(negedge clk);
    x_val = 8'd17; y_val = 8'd200; z_val = 8'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      if (k == 19) #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if (done_w[2] !== exp_done[k]) $display("FAIL b2b_done@%0d: got %b want %b", k, done_w[2], exp_done[k]);
      else passed++;
      if (k >= model_latency(2)) begin
        checks++;
        if (result_w[2] !== 18'(exp)) $display("FAIL b2b_result@%0d: got %0d want %0d", k, result_w[2], exp);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int exp;
    pulse_start(200, 150, 100);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done_w[i] !== 1'b0 || result_w[i] !== 18'd0)
        $display("FAIL midreset_clear[%0d]: got done %b result %0d want done 0 result 0", i, done_w[i], result_w[i]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch(30, 1'b0);
    checks++;
    if (pulses[2] != 0) $display("FAIL midreset_no_done: got %0d pulses want 0", pulses[2]);
    else passed++;
    exp = model_sumsq(5, 71, 255);
    pulse_start(5, 71, 255);
    watch(30, 1'b0);
    checks++;
    if (res_seen[2] !== 18'(exp) || first_lat[2] != model_latency(2))
      $display("FAIL midreset_recover: got result %0d lat %0d want result %0d lat %0d",
               res_seen[2], first_lat[2], exp, model_latency(2));
    else passed++;
  endtask

  task automatic test_mul_bits();
    int exp;
    exp = model_sumsq(5, 71, 255);
    pulse_start(5, 71, 255);
    watch(30, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (first_lat[i] != model_latency(i))
        $display("FAIL mulbits_latency mb=%0d: got %0d want %0d", 1 << i, first_lat[i], model_latency(i));
      else passed++;
      checks++;
      if (res_seen[i] !== 18'(exp) || pulses[i] != 1)
        $display("FAIL mulbits_result mb=%0d: got %0d (%0d pulses) want %0d (1 pulse)", 1 << i, res_seen[i], pulses[i], exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_operand_hold();
    test_back_to_back();
    settle();
    test_reset_mid_calc();
    test_mul_bits();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
